// File: rtl/serial_add_if.sv
// Request/response channel of the bit-serial add/subtract unit.
// master = requester/consumer side, slave = the arithmetic unit.
interface serial_add_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             op_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output req_valid, a, b, c_in, op_sub, rsp_ready,
    input  req_ready, rsp_valid, sum, c_out, overflow, zero
  );

  modport slave (
    input  req_valid, a, b, c_in, op_sub, rsp_ready,
    output req_ready, rsp_valid, sum, c_out, overflow, zero
  );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract: one full-adder cell fed LSB first, carry held in a flop.
// WIDTH shift cycles per operation; result registered on entry to DONE.
module serial_add_unit #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus,
  output logic         busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic             carry, s, co, last;
  logic [CW-1:0]    count;

  assign s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign co   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = (count == CW'(WIDTH - 1));
  // Sum bit enters the MSB; the concat keeps the shift legal for WIDTH=1.
  assign res_nx = WIDTH'({s, res_sh} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) state_nx = SHIFT;
      end
      SHIFT: if (last) state_nx = DONE;
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      carry        <= 1'b0;
      count        <= '0;
      bus.sum      <= '0;
      bus.c_out    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_sh <= '0;
          count  <= '0;
          if (bus.req_valid) begin
            // Subtract is A + ~B + 1: invert B and force the carry in.
            a_sh  <= bus.a;
            b_sh  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub ? 1'b1 : bus.c_in;
          end
        end
        SHIFT: begin
          res_sh <= res_nx;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= co;
          count  <= count + 1'b1;
          if (last) begin
            // carry here is the carry into the MSB cell.
            bus.sum      <= res_nx;
            bus.c_out    <= co;
            bus.overflow <= carry ^ co;
            bus.zero     <= (res_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed + back-to-back random checks of serial_add_unit at WIDTH 1, 4 and 8.
module tb_serial_add_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_r = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ndone = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Directed instance
  serial_add_if #(4) d_if ();
  serial_add_unit #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(d_if), .busy(busy));

  task automatic start(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sub);
    int n;
    d_if.a = a; d_if.b = b; d_if.c_in = ci; d_if.op_sub = sub;
    d_if.req_valid = 1'b1;
    n = 0;
    while (!d_if.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("start_rdy", 32'(d_if.req_ready), 1);
    @(posedge clk); #1;
    d_if.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!d_if.rsp_valid && n < 12) begin @(posedge clk); #1; n++; end
    chk("latency", n, 4);
  endtask

  task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b,
                    input logic ci, input logic sub, input logic [6:0] exp);
    start(a, b, ci, sub);
    wait_rsp();
    chk(tag, 32'({d_if.sum, d_if.c_out, d_if.overflow, d_if.zero}), 32'(exp));
    d_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    d_if.rsp_ready = 1'b0;
    chk({tag, "_rel"}, 32'({d_if.rsp_valid, d_if.req_ready}), 32'b01);
  endtask

  // Random back-to-back instances
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
    serial_add_if #(W) r_if ();
    logic r_busy;
    serial_add_unit #(.WIDTH(W)) u (.clk(clk), .rst(rst_r), .bus(r_if), .busy(r_busy));

    initial begin
      logic [W-1:0] ea, eb, bb, es;
      logic [W:0]   full;
      logic         ec, sub, eo;
      int           n, acc, prev;
      r_if.req_valid = 1'b0; r_if.rsp_ready = 1'b1;
      r_if.a = '0; r_if.b = '0; r_if.c_in = 1'b0; r_if.op_sub = 1'b0;
      prev = 0;
      wait (rst_r == 1'b0);
      @(posedge clk); #1;
      r_if.req_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
        ea = W'($urandom); eb = W'($urandom);
        ec = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        r_if.a = ea; r_if.b = eb; r_if.c_in = ec; r_if.op_sub = sub;
        n = 0;
        while (!r_if.req_ready && n < 2 * W + 8) begin @(posedge clk); #1; n++; end
        chk("r_rdy", 32'(r_if.req_ready), 1);
        @(posedge clk); #1;
        acc = cyc;
        if (i > 0) chk("r_gap", acc - prev, W + 2);
        prev = acc;
        bb   = sub ? ~eb : eb;
        full = {1'b0, ea} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : ec);
        es   = full[W-1:0];
        eo   = (ea[W-1] == bb[W-1]) && (es[W-1] != ea[W-1]);
        n = 0;
        while (!r_if.rsp_valid && n < W + 4) begin @(posedge clk); #1; n++; end
        chk("r_lat", n, W);
        chk("r_res", 32'({r_if.sum, r_if.c_out, r_if.overflow, r_if.zero}),
            32'({es, full[W], eo, (es == '0)}));
      end
      r_if.req_valid = 1'b0;
      ndone++;
    end
  end

  initial begin
    rst_r = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_r = 1'b0;
  end

  initial begin
    int n;
    d_if.req_valid = 1'b0; d_if.rsp_ready = 1'b0;
    d_if.a = '0; d_if.b = '0; d_if.c_in = 1'b0; d_if.op_sub = 1'b0;
    #1;
    chk("reset", 32'({d_if.req_ready, d_if.rsp_valid, d_if.sum, d_if.c_out,
                      d_if.overflow, d_if.zero, busy}), 32'b10_0000_0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op("add_5_3",  4'd5,  4'd3, 1'b0, 1'b0, 7'b1000_0_1_0);
    op("add_15_1", 4'd15, 4'd1, 1'b0, 1'b0, 7'b0000_1_0_1);
    op("add_7_0c", 4'd7,  4'd0, 1'b1, 1'b0, 7'b1000_0_1_0);
    op("sub_3_5",  4'd3,  4'd5, 1'b0, 1'b1, 7'b1110_0_0_0);
    op("sub_5_3",  4'd5,  4'd3, 1'b0, 1'b1, 7'b0010_1_0_0);
    op("sub_8_1",  4'd8,  4'd1, 1'b1, 1'b1, 7'b0111_1_1_0);

    // Stall in DONE; a request during the stall must be ignored
    start(4'd6, 4'd1, 1'b0, 1'b0);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin d_if.a = 4'd1; d_if.b = 4'd1; d_if.req_valid = 1'b1; end
      chk("hold", 32'({d_if.rsp_valid, d_if.req_ready, d_if.sum, d_if.c_out,
                       d_if.overflow, d_if.zero}), 32'b1_0_0111_000);
      @(posedge clk); #1;
    end
    d_if.req_valid = 1'b0;
    d_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    d_if.rsp_ready = 1'b0;
    chk("drop", 32'({busy, d_if.rsp_valid, d_if.sum}), 32'b0_0_0111);
    @(posedge clk); #1;
    chk("no_stale", 32'(busy), 0);

    // Reset mid-SHIFT aborts the operation
    start(4'd9, 4'd9, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort", 32'({busy, d_if.rsp_valid, d_if.req_ready, d_if.sum}), 32'b0_0_1_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    op("add_2_2", 4'd2, 4'd2, 1'b0, 1'b0, 7'b0100_0_0_0);

    n = 0;
    while (ndone < 3 && n < 20000) begin @(posedge clk); n++; end
    chk("rand_done", ndone, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
